// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode definitions: exception codes and the fetched-instruction record.
package inst_queue_pkg;

    typedef enum logic [2:0] {
        EXCP_NONE = 3'd0,
        EXCP_ADEF = 3'd1,
        EXCP_TLBR = 3'd2,
        EXCP_PIF  = 3'd3,
        EXCP_PPI  = 3'd4,
        EXCP_PME  = 3'd5,
        EXCP_INE  = 3'd6,
        EXCP_SYS  = 3'd7
    } excp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_br_taken;
        logic [31:0] pred_br_target;
        logic        have_excp;
        excp_t       excp_type;
    } fetch_entry_t;

    // Number of set bits in a two-lane valid/handshake vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: two-wide push, two-wide pop,
// circular flop storage, single-cycle flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [1:0]         in_valid,
    output logic               in_ready,
    input  fetch_entry_t [1:0] in_entry,
    output logic [1:0]         out_valid,
    output fetch_entry_t [1:0] out_entry,
    input  logic [1:0]         out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [1:0] push_en;
    logic [1:0] push_n;
    logic [1:0] pop_n;

    // Room for a full two-wide push; deliberately ignores this cycle's pop so
    // in_ready never depends on decode's handshake.
    assign in_ready = (count_reg <= CNT_W'(DEPTH - 2));
    assign push_en  = in_ready ? in_valid : 2'b00;
    assign push_n   = popcount2(push_en);
    assign pop_n    = popcount2(out_valid & out_ready);

    // Read ports: head and head+1, pointer arithmetic wraps naturally.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            assign out_valid[gi] = (count_reg > CNT_W'(gi));
            assign out_entry[gi] = mem[head_reg + PTR_W'(gi)];
        end
    endgenerate

    // Next-state pointers and occupancy; flush discards the cycle's push and pop.
    always_comb begin
        head_next  = head_reg + PTR_W'(pop_n);
        tail_next  = tail_reg + PTR_W'(push_n);
        count_next = count_reg + CNT_W'(push_n) - CNT_W'(pop_n);
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Two write ports: lane 0 at tail, lane 1 at tail+1; contents survive reset/flush.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            for (int i = 0; i < 2; i++) begin
                if (push_en[i]) begin
                    mem[tail_reg + PTR_W'(i)] <= in_entry[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic [1:0]         in_valid;
    logic               in_ready;
    fetch_entry_t [1:0] in_entry;
    logic [1:0]         out_valid;
    fetch_entry_t [1:0] out_entry;
    logic [1:0]         out_ready;

    int total = 0;
    int bad   = 0;

    fetch_entry_t q[$];
    int head_idx = 0;
    int tail_idx = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_entry (out_entry),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic fetch_entry_t rand_entry(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc             = pc;
        e.inst           = $urandom;
        e.pred_br_taken  = 1'($urandom_range(0, 1));
        e.pred_br_target = $urandom;
        e.have_excp      = 1'($urandom_range(0, 1));
        e.excp_type      = excp_t'($urandom_range(0, 7));
        return e;
    endfunction

    // One clock of stimulus; the model follows the queue rules directly.
    task automatic drive(input logic fl, input logic [1:0] iv, input fetch_entry_t e0,
                         input fetch_entry_t e1, input logic [1:0] ordy);
        int  pre;
        int  npop;
        bit  rdy;
        flush       = fl;
        in_valid    = iv;
        in_entry[0] = e0;
        in_entry[1] = e1;
        out_ready   = ordy;
        pre = q.size();
        rdy = (DEPTH - pre) >= 2;
        @(posedge clk);
        if (fl) begin
            q.delete();
            head_idx = 0;
            tail_idx = 0;
        end else begin
            npop = 0;
            if (pre >= 1 && ordy[0]) npop++;
            if (pre >= 2 && ordy[1]) npop++;
            repeat (npop) void'(q.pop_front());
            head_idx = (head_idx + npop) % DEPTH;
            if (rdy) begin
                if (iv[0]) begin q.push_back(e0); tail_idx++; end
                if (iv[1]) begin q.push_back(e1); tail_idx++; end
                tail_idx = tail_idx % DEPTH;
            end
        end
        $display("txn t=%0t flush=%0d in_valid=%b out_ready=%b pc0=%h pc1=%h model_count=%0d",
                 $time, fl, iv, ordy, e0.pc, e1.pc, q.size());
        #1;
        flush     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b00;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        head_idx = 0;
        tail_idx = 0;
        $display("txn t=%0t reset", $time);
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 2'b11, rand_entry(32'h100), rand_entry(32'h104), 2'b00);
        drive(1'b0, 2'b01, rand_entry(32'h108), rand_entry(32'h0), 2'b00);
        do_reset();
        total++;
        if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_out_valid got=%b want=00", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (int'(dut.count_reg) !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", dut.count_reg); end
    endtask

    task automatic test_two_lane();
        fetch_entry_t a, b;
        do_reset();
        a = rand_entry(32'h1c000000);
        b = rand_entry(32'h1c000004);
        drive(1'b0, 2'b11, a, b, 2'b00);
        total++;
        if (out_valid !== 2'b11) begin bad++; $display("FAIL two_lane_valid got=%b want=11", out_valid); end
        total++;
        if (out_entry[0].pc !== 32'h1c000000) begin bad++; $display("FAIL two_lane_pc0 got=%h want=1c000000", out_entry[0].pc); end
        total++;
        if (out_entry[1].pc !== 32'h1c000004) begin bad++; $display("FAIL two_lane_pc1 got=%h want=1c000004", out_entry[1].pc); end
        total++;
        if (out_entry[1] !== b) begin bad++; $display("FAIL two_lane_entry1 got=%h want=%h", out_entry[1], b); end
        total++;
        if (int'(dut.count_reg) !== 2) begin bad++; $display("FAIL two_lane_count got=%0d want=2", dut.count_reg); end
    endtask

    task automatic test_fill();
        logic [31:0] pc;
        logic [31:0] exp_pc;
        do_reset();
        pc = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b11, rand_entry(pc), rand_entry(pc + 4), 2'b00);
            pc += 8;
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_at6 got=%b want=1", in_ready); end
        drive(1'b0, 2'b01, rand_entry(pc), rand_entry(32'h0), 2'b00);
        pc += 4;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_at7 got=%b want=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b11, rand_entry(32'hdead0000), rand_entry(32'hdead0004), 2'b00);
        end
        total++;
        if (int'(dut.count_reg) !== 7) begin bad++; $display("FAIL fill_count_hold got=%0d want=7", dut.count_reg); end
        // Pop one: in_ready stays low in that cycle, push is dropped, recovers after.
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_during_pop got=%b want=0", in_ready); end
        drive(1'b0, 2'b11, rand_entry(32'hbeef0000), rand_entry(32'hbeef0004), 2'b01);
        total++;
        if (int'(dut.count_reg) !== 6) begin bad++; $display("FAIL fill_count_after_pop got=%0d want=6", dut.count_reg); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_recover got=%b want=1", in_ready); end
        exp_pc = 32'h2004;
        while (q.size() > 0) begin
            total++;
            if (out_entry[0].pc !== exp_pc) begin bad++; $display("FAIL fill_drain_pc got=%h want=%h", out_entry[0].pc, exp_pc); end
            drive(1'b0, 2'b00, rand_entry(32'h0), rand_entry(32'h0), 2'b01);
            exp_pc += 4;
        end
    endtask

    task automatic test_steady();
        logic [31:0] push_pc;
        logic [31:0] pop_pc;
        do_reset();
        push_pc = 32'h1c000000;
        pop_pc  = 32'h1c000000;
        drive(1'b0, 2'b11, rand_entry(push_pc), rand_entry(push_pc + 4), 2'b00);
        push_pc += 8;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (out_valid !== 2'b11 || out_entry[0].pc !== pop_pc || out_entry[1].pc !== pop_pc + 4) begin
                bad++;
                $display("FAIL steady_order cyc=%0d got=%b/%h/%h want=11/%h/%h",
                         i, out_valid, out_entry[0].pc, out_entry[1].pc, pop_pc, pop_pc + 4);
            end
            drive(1'b0, 2'b11, rand_entry(push_pc), rand_entry(push_pc + 4), 2'b11);
            push_pc += 8;
            pop_pc  += 8;
            total++;
            if (int'(dut.count_reg) !== 2 || int'(dut.head_reg) !== head_idx || int'(dut.tail_reg) !== tail_idx) begin
                bad++;
                $display("FAIL steady_ptrs cyc=%0d got count=%0d head=%0d tail=%0d want count=2 head=%0d tail=%0d",
                         i, dut.count_reg, dut.head_reg, dut.tail_reg, head_idx, tail_idx);
            end
        end
    endtask

    task automatic test_excp_passthrough();
        fetch_entry_t e;
        do_reset();
        e = rand_entry(32'h1c000040);
        e.have_excp      = 1'b1;
        e.excp_type      = EXCP_ADEF;
        e.pred_br_taken  = 1'b1;
        e.pred_br_target = 32'h1c000100;
        drive(1'b0, 2'b01, e, rand_entry(32'h0), 2'b00);
        total++;
        if (out_entry[0].have_excp !== 1'b1 || out_entry[0].excp_type !== EXCP_ADEF) begin
            bad++;
            $display("FAIL excp_fields got=%b/%0d want=1/%0d", out_entry[0].have_excp, out_entry[0].excp_type, EXCP_ADEF);
        end
        total++;
        if (out_entry[0].pred_br_taken !== 1'b1 || out_entry[0].pred_br_target !== 32'h1c000100) begin
            bad++;
            $display("FAIL excp_pred got=%b/%h want=1/1c000100", out_entry[0].pred_br_taken, out_entry[0].pred_br_target);
        end
        total++;
        if (out_entry[0] !== e) begin bad++; $display("FAIL excp_entry got=%h want=%h", out_entry[0], e); end
    endtask

    task automatic test_flush();
        fetch_entry_t x;
        do_reset();
        drive(1'b0, 2'b11, rand_entry(32'h3000), rand_entry(32'h3004), 2'b00);
        drive(1'b0, 2'b11, rand_entry(32'h3008), rand_entry(32'h300c), 2'b00);
        drive(1'b0, 2'b01, rand_entry(32'h3010), rand_entry(32'h0), 2'b00);
        total++;
        if (int'(dut.count_reg) !== 5) begin bad++; $display("FAIL flush_pre_count got=%0d want=5", dut.count_reg); end
        drive(1'b1, 2'b11, rand_entry(32'h4000), rand_entry(32'h4004), 2'b11);
        total++;
        if (out_valid !== 2'b00 || in_ready !== 1'b1 || int'(dut.count_reg) !== 0) begin
            bad++;
            $display("FAIL flush_state got valid=%b ready=%b count=%0d want valid=00 ready=1 count=0",
                     out_valid, in_ready, dut.count_reg);
        end
        drive(1'b1, 2'b11, rand_entry(32'h5000), rand_entry(32'h5004), 2'b00);
        total++;
        if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_repeat got=%b want=00", out_valid); end
        x = rand_entry(32'h6000);
        drive(1'b0, 2'b01, x, rand_entry(32'h0), 2'b00);
        total++;
        if (out_valid !== 2'b01 || out_entry[0] !== x) begin
            bad++;
            $display("FAIL flush_push_after got=%b/%h want=01/%h", out_valid, out_entry[0].pc, x.pc);
        end
    endtask

    task automatic test_one_entry();
        do_reset();
        drive(1'b0, 2'b11, rand_entry(32'h7000), rand_entry(32'h7004), 2'b01);
        drive(1'b0, 2'b00, rand_entry(32'h0), rand_entry(32'h0), 2'b01);
        total++;
        if (out_valid !== 2'b01) begin bad++; $display("FAIL one_valid got=%b want=01", out_valid); end
        drive(1'b0, 2'b00, rand_entry(32'h0), rand_entry(32'h0), 2'b11);
        total++;
        if (int'(dut.count_reg) !== 0 || out_valid !== 2'b00) begin
            bad++;
            $display("FAIL one_pop got count=%0d valid=%b want count=0 valid=00", dut.count_reg, out_valid);
        end
        total++;
        if (int'(dut.head_reg) !== head_idx) begin bad++; $display("FAIL one_head got=%0d want=%0d", dut.head_reg, head_idx); end
    endtask

    task automatic test_random();
        logic [1:0] iv, ordy;
        logic       fl;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            total++;
            if (out_valid !== {q.size() >= 2, q.size() >= 1} || in_ready !== ((DEPTH - q.size()) >= 2)
                || int'(dut.count_reg) !== q.size()) begin
                bad++;
                $display("FAIL rand_ctrl cyc=%0d got valid=%b ready=%b count=%0d want count=%0d",
                         i, out_valid, in_ready, dut.count_reg, q.size());
            end
            if (q.size() >= 1) begin
                total++;
                if (out_entry[0] !== q[0]) begin bad++; $display("FAIL rand_lane0 cyc=%0d got=%h want=%h", i, out_entry[0], q[0]); end
            end
            if (q.size() >= 2) begin
                total++;
                if (out_entry[1] !== q[1]) begin bad++; $display("FAIL rand_lane1 cyc=%0d got=%h want=%h", i, out_entry[1], q[1]); end
            end
            case ($urandom_range(0, 2))
                0: iv = 2'b00;
                1: iv = 2'b01;
                default: iv = 2'b11;
            endcase
            case ($urandom_range(0, 2))
                0: ordy = 2'b00;
                1: ordy = 2'b01;
                default: ordy = 2'b11;
            endcase
            fl = ($urandom_range(0, 31) == 0);
            drive(fl, iv, rand_entry($urandom), rand_entry($urandom), ordy);
        end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 2'b00;
        out_ready   = 2'b00;
        in_entry[0] = '0;
        in_entry[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_two_lane();
        test_fill();
        test_steady();
        test_excp_passthrough();
        test_flush();
        test_one_entry();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
